// File: rtl/iq_polyphase_interp.sv
// Two-channel (I/Q) polyphase interpolating FIR: each accepted input pair yields UPS filtered output pairs.
// Optional macro SATURATE_EN clamps the sized output instead of wrapping it.
module iq_polyphase_interp #(
    parameter int DATA_W    = 4,
    parameter int COEF_W    = 8,
    parameter int UPS       = 4,
    parameter int NUM_TAPS  = 72,
    parameter int ADDR_W    = 7,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_i,
    input  logic [DATA_W-1:0]       in_q,
    input  logic                    coef_we,
    input  logic [ADDR_W-1:0]       coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_i,
    output logic [OUT_W-1:0]        out_q,
    output logic [$clog2(UPS)-1:0]  out_phase
);

    localparam int M     = NUM_TAPS / UPS;
    localparam int PH_W  = $clog2(UPS);
    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(M);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [PH_W-1:0]           phase;
    logic                      ready_en;
    logic                      last_phase;
    logic                      handshake;

    logic [COEF_W-1:0]         coef [NUM_TAPS];
    logic [DATA_W-1:0]         x_i  [M];
    logic [DATA_W-1:0]         x_q  [M];

    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   c_ext;
    logic signed [ACC_W-1:0]   acc_i;
    logic signed [ACC_W-1:0]   acc_q;

    assign last_phase = (phase == PH_W'(UPS - 1));
    assign handshake  = in_valid & in_ready;

    // Shift, optionally clamp, then narrow the full-precision sum to the output width.
    function automatic logic [OUT_W-1:0] size_out(input logic signed [ACC_W-1:0] acc);
`ifdef SATURATE_EN
        localparam int BIG_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
        localparam logic signed [BIG_W-1:0] SAT_MAX = BIG_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
        localparam logic signed [BIG_W-1:0] SAT_MIN = ~SAT_MAX;
        logic signed [BIG_W-1:0] wide;
        wide = BIG_W'(acc >>> OUT_SHIFT);
        if (wide > SAT_MAX)
            return OUT_W'(SAT_MAX);
        else if (wide < SAT_MIN)
            return OUT_W'(SAT_MIN);
        else
            return OUT_W'(wide);
`else
        return OUT_W'(acc >>> OUT_SHIFT);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = RUN;
            RUN:     if (last_phase && !handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (ready_en) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                RUN:     in_ready = last_phase;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // ready_en keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
            phase    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (state == RUN && !last_phase) phase <= phase + PH_W'(1);
            else                             phase <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < M; k++) begin
                x_i[k] <= '0;
                x_q[k] <= '0;
            end
        end else if (handshake) begin
            x_i[0] <= in_i;
            x_q[0] <= in_q;
            for (int k = 1; k < M; k++) begin
                x_i[k] <= x_i[k-1];
                x_q[k] <= x_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
        end else if (coef_we && int'(coef_addr) < NUM_TAPS) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Phase p only touches taps p, p+UPS, p+2*UPS, ... so zero-stuffed samples never reach a multiplier.
    always_comb begin
        acc_i = '0;
        acc_q = '0;
        idx   = '0;
        c_ext = '0;
        for (int k = 0; k < M; k++) begin
            idx   = IDX_W'(k * UPS) + IDX_W'(phase);
            c_ext = ACC_W'($signed(coef[idx]));
            acc_i = acc_i + c_ext * ACC_W'($signed(x_i[k]));
            acc_q = acc_q + c_ext * ACC_W'($signed(x_q[k]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_phase <= '0;
        end else begin
            out_valid <= (state == RUN);
            if (state == RUN) begin
                out_i     <= size_out(acc_i);
                out_q     <= size_out(acc_q);
                out_phase <= phase;
            end
        end
    end

endmodule

// File: tb/tb_iq_polyphase_interp.sv
// Self-checking bench for iq_polyphase_interp: queue-based reference model plus directed literal checks.
module tb_iq_polyphase_interp;

    localparam int DATA_W    = 4;
    localparam int COEF_W    = 8;
    localparam int UPS       = 4;
    localparam int NUM_TAPS  = 72;
    localparam int ADDR_W    = 7;
    localparam int OUT_W     = 12;
    localparam int OUT_SHIFT = 0;
    localparam int M         = NUM_TAPS / UPS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_i = '0;
    logic [DATA_W-1:0] in_q = '0;
    logic              coef_we = 1'b0;
    logic [ADDR_W-1:0] coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_i;
    logic [OUT_W-1:0]  out_q;
    logic [1:0]        out_phase;

    int total = 0;
    int bad   = 0;

    int  coef_m [NUM_TAPS];
    int  hist_i [M];
    int  hist_q [M];
    int  pend   [$];
    bit  alive     = 1'b0;
    bit  take_m    = 1'b0;
    int  ph_m      = 0;
    bit  exp_valid = 1'b0;
    int  exp_i     = 0;
    int  exp_q     = 0;
    int  exp_phase = 0;

    int cap_i  [$];
    int cap_q  [$];
    int cap_ph [$];

    iq_polyphase_interp #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .UPS(UPS), .NUM_TAPS(NUM_TAPS),
        .ADDR_W(ADDR_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid), .out_i(out_i),
        .out_q(out_q), .out_phase(out_phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output sizing straight from the arithmetic rule: shift, then wrap or clamp to OUT_W bits.
    function automatic int sizeModel(input longint acc);
        longint s   = acc >>> OUT_SHIFT;
        longint lim = longint'(1) << (OUT_W - 1);
`ifdef SATURATE_EN
        if (s > lim - 1) return int'(lim - 1);
        if (s < -lim)    return int'(-lim);
        return int'(s);
`else
        s = s % (2 * lim);
        if (s < 0)    s = s + 2 * lim;
        if (s >= lim) s = s - 2 * lim;
        return int'(s);
`endif
    endfunction

    function automatic longint phaseAcc(input int p, input bit use_q);
        longint a = 0;
        for (int k = 0; k < M; k++)
            a = a + longint'(coef_m[k*UPS + p]) * longint'(use_q ? hist_q[k] : hist_i[k]);
        return a;
    endfunction

    // Reference model: each accepted pair queues UPS phases, one emitted per clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) coef_m[k] = 0;
            for (int k = 0; k < M; k++) begin
                hist_i[k] = 0;
                hist_q[k] = 0;
            end
            pend.delete();
            alive     = 1'b0;
            exp_valid = 1'b0;
            exp_i     = 0;
            exp_q     = 0;
            exp_phase = 0;
        end else begin
            take_m = alive && in_valid && (pend.size() <= 1);
            if (pend.size() > 0) begin
                ph_m      = pend.pop_front();
                exp_valid = 1'b1;
                exp_phase = ph_m;
                exp_i     = sizeModel(phaseAcc(ph_m, 1'b0));
                exp_q     = sizeModel(phaseAcc(ph_m, 1'b1));
            end else begin
                exp_valid = 1'b0;
            end
            if (coef_we && int'(coef_addr) < NUM_TAPS)
                coef_m[coef_addr] = int'($signed(coef_data));
            if (take_m) begin
                for (int k = M - 1; k > 0; k--) begin
                    hist_i[k] = hist_i[k-1];
                    hist_q[k] = hist_q[k-1];
                end
                hist_i[0] = int'($signed(in_i));
                hist_q[0] = int'($signed(in_q));
                for (int p = 0; p < UPS; p++) pend.push_back(p);
            end
            alive = 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("out_valid", int'(out_valid), int'(exp_valid));
        checkOutput("in_ready", int'(in_ready), int'(alive && pend.size() <= 1));
        checkOutput("out_i", int'($signed(out_i)), exp_i);
        checkOutput("out_q", int'($signed(out_q)), exp_q);
        if (exp_valid) checkOutput("out_phase", int'(out_phase), exp_phase);
        if (out_valid) begin
            cap_i.push_back(int'($signed(out_i)));
            cap_q.push_back(int'($signed(out_q)));
            cap_ph.push_back(int'(out_phase));
        end
    end

    task automatic applyStimulus(input int i, input int q);
        int n = 0;
        in_valid = 1'b1;
        in_i     = DATA_W'(i);
        in_q     = DATA_W'(q);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("handshake_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = ADDR_W'(addr);
        coef_data = COEF_W'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic clearCapture();
        cap_i.delete();
        cap_q.delete();
        cap_ph.delete();
    endtask

    task automatic drain();
        repeat (UPS + 2) @(negedge clk);
    endtask

    task automatic impulseTest(input bit expect_zero);
        clearCapture();
        applyStimulus(1, -1);
        for (int n = 1; n < M; n++) applyStimulus(0, 0);
        drain();
        checkOutput("impulse_count", cap_i.size(), NUM_TAPS);
        for (int j = 0; j < NUM_TAPS; j++) begin
            if (j < cap_i.size()) begin
                checkOutput("impulse_i", cap_i[j], expect_zero ? 0 : j);
                checkOutput("impulse_q", cap_q[j], expect_zero ? 0 : -j);
                checkOutput("impulse_ph", cap_ph[j], j % UPS);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_i", int'(out_i), 0);
        checkOutput("reset_out_q", int'(out_q), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        $display("[TB] impulse response with ramp coefficients");
        for (int k = 0; k < NUM_TAPS; k++) writeCoef(k, k);
        impulseTest(1'b0);

        $display("[TB] out-of-range coefficient write");
        writeCoef(100, 55);
        impulseTest(1'b0);

        $display("[TB] steady DC input");
        clearCapture();
        for (int n = 0; n < 20; n++) applyStimulus(1, 0);
        drain();
        checkOutput("dc_count", cap_i.size(), 20 * UPS);
        if (cap_i.size() == 20 * UPS) begin
            for (int p = 0; p < UPS; p++) begin
                checkOutput("dc_i", cap_i[19*UPS + p], 612 + 18 * p);
                checkOutput("dc_q", cap_q[19*UPS + p], 0);
            end
        end

        $display("[TB] output sizing at full scale");
        for (int k = 0; k < NUM_TAPS; k++) writeCoef(k, 127);
        clearCapture();
        for (int n = 0; n < M; n++) applyStimulus(-8, -8);
        drain();
        checkOutput("sat_count", cap_i.size(), NUM_TAPS);
        if (cap_i.size() == NUM_TAPS) begin
            for (int p = 0; p < UPS; p++) begin
`ifdef SATURATE_EN
                checkOutput("sat_i", cap_i[(M-1)*UPS + p], -2048);
                checkOutput("sat_q", cap_q[(M-1)*UPS + p], -2048);
`else
                checkOutput("sat_i", cap_i[(M-1)*UPS + p], -1904);
                checkOutput("sat_q", cap_q[(M-1)*UPS + p], -1904);
`endif
            end
        end

        $display("[TB] handshake with a gap");
        clearCapture();
        applyStimulus(1, 2);
        applyStimulus(-3, 1);
        repeat (5) @(negedge clk);
        applyStimulus(2, -2);
        drain();
        checkOutput("hs_count", cap_i.size(), 3 * UPS);

        $display("[TB] reset during RUN");
        applyStimulus(5, -5);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_out_i", int'(out_i), 0);
        checkOutput("midrst_out_q", int'(out_q), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        impulseTest(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
